// File: rtl/pma_region_table_if.sv
// pma_region_table_if
// Bundles the config port and the lookup port of pma_region_table.
//   config : cfg_req_i / cfg_we_i / cfg_addr_i / cfg_wdata_i in,
//            cfg_rvalid_o / cfg_rdata_o / cfg_err_o out (one cycle later)
//   lookup : lkp_valid_i / lkp_addr_i in,
//            lkp_valid_o / lkp_hit_o / lkp_region_o / attribute flags out
// The "master" modport is the requester (SoC config bus / fetch / LSU).
// The "slave" modport is the table itself.
interface pma_region_table_if #(
  parameter int unsigned NR_REGIONS = 4,
  parameter int unsigned ADDR_WIDTH = 64
);
  localparam int unsigned CFG_AW = $clog2(NR_REGIONS) + 2;
  localparam int unsigned IDX_W  = (NR_REGIONS > 1) ? $clog2(NR_REGIONS) : 1;

  logic                  cfg_req_i;
  logic                  cfg_we_i;
  logic [CFG_AW-1:0]     cfg_addr_i;
  logic [ADDR_WIDTH-1:0] cfg_wdata_i;
  logic                  cfg_rvalid_o;
  logic [ADDR_WIDTH-1:0] cfg_rdata_o;
  logic                  cfg_err_o;

  logic                  lkp_valid_i;
  logic [ADDR_WIDTH-1:0] lkp_addr_i;
  logic                  lkp_valid_o;
  logic                  lkp_hit_o;
  logic [IDX_W-1:0]      lkp_region_o;
  logic                  lkp_cached_o;
  logic                  lkp_exec_o;
  logic                  lkp_nonidem_o;

  modport master (
    output cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i, lkp_valid_i, lkp_addr_i,
    input  cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
    input  lkp_valid_o, lkp_hit_o, lkp_region_o, lkp_cached_o, lkp_exec_o, lkp_nonidem_o
  );

  modport slave (
    input  cfg_req_i, cfg_we_i, cfg_addr_i, cfg_wdata_i, lkp_valid_i, lkp_addr_i,
    output cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
    output lkp_valid_o, lkp_hit_o, lkp_region_o, lkp_cached_o, lkp_exec_o, lkp_nonidem_o
  );
endinterface

// File: rtl/pma_region_table.sv
// pma_region_table
// Runtime-programmable physical-memory-attribute table. Each of NR_REGIONS
// entries holds BASE, LEN and a 4-bit ATTR {lock, nonidem, exec, cached}.
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset; reloads the table from RST_*
//   bus    - pma_region_table_if.slave (config port + lookup port)
// Config address is {region index, reg}: reg 0 BASE, 1 LEN, 2 ATTR, 3 reserved.
// Both ports answer one cycle after the request; lookups see the table as it
// was before any write issued in the same cycle.
module pma_region_table #(
  parameter int unsigned                         NR_REGIONS = 4,
  parameter int unsigned                         ADDR_WIDTH = 64,
  parameter logic [NR_REGIONS*ADDR_WIDTH-1:0]    RST_BASE   = '0,
  parameter logic [NR_REGIONS*ADDR_WIDTH-1:0]    RST_LEN    = '0,
  parameter logic [NR_REGIONS*4-1:0]             RST_ATTR   = '0
) (
  input logic                clk_i,
  input logic                rst_i,
  pma_region_table_if.slave  bus
);
  localparam int unsigned CFG_AW = $clog2(NR_REGIONS) + 2;
  localparam int unsigned IDX_W  = (NR_REGIONS > 1) ? $clog2(NR_REGIONS) : 1;

  logic [ADDR_WIDTH-1:0] base_r [NR_REGIONS];
  logic [ADDR_WIDTH-1:0] len_r  [NR_REGIONS];
  logic [3:0]            attr_r [NR_REGIONS];

  logic [CFG_AW-1:0]     cfg_shift_s;
  logic                  cfg_idx_ok_s;
  logic [IDX_W-1:0]      cfg_idx_s;
  logic [1:0]            cfg_reg_s;
  logic                  cfg_err_s;
  logic [ADDR_WIDTH-1:0] cfg_rdata_s;
  logic                  cfg_wen_s;

  logic                  lkp_hit_s;
  logic [IDX_W-1:0]      lkp_region_s;
  logic [2:0]            lkp_attr_s;

  logic                  cfg_rvalid_r;
  logic [ADDR_WIDTH-1:0] cfg_rdata_r;
  logic                  cfg_err_r;
  logic                  lkp_valid_r;
  logic                  lkp_hit_r;
  logic [IDX_W-1:0]      lkp_region_r;
  logic [2:0]            lkp_attr_r;

  // Offset form of the range test: no wrap-around below BASE, and an
  // overflowing BASE+LEN simply covers everything up to the top.
  function automatic logic region_match(input logic [ADDR_WIDTH-1:0] base,
                                        input logic [ADDR_WIDTH-1:0] len,
                                        input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - base;
    return (len != '0) && (addr >= base) && (off < len);
  endfunction

  // Split the config address; an index beyond NR_REGIONS is treated as an error.
  assign cfg_shift_s  = bus.cfg_addr_i >> 2;
  assign cfg_idx_ok_s = (cfg_shift_s < CFG_AW'(NR_REGIONS));
  assign cfg_idx_s    = cfg_shift_s[IDX_W-1:0];
  assign cfg_reg_s    = bus.cfg_addr_i[1:0];

  // Config decode: read mux, error detection and write enable.
  always_comb begin
    cfg_err_s   = 1'b0;
    cfg_rdata_s = '0;
    if (!cfg_idx_ok_s) begin
      cfg_err_s = 1'b1;
    end else begin
      case (cfg_reg_s)
        2'd0:    cfg_rdata_s = base_r[cfg_idx_s];
        2'd1:    cfg_rdata_s = len_r[cfg_idx_s];
        2'd2:    cfg_rdata_s = {{(ADDR_WIDTH-4){1'b0}}, attr_r[cfg_idx_s]};
        default: cfg_err_s   = 1'b1;
      endcase
      if (bus.cfg_we_i) begin
        // Writes return no data; a locked region refuses every write.
        cfg_rdata_s = '0;
        if (attr_r[cfg_idx_s][3]) begin
          cfg_err_s = 1'b1;
        end else begin
          cfg_err_s = cfg_err_s;
        end
      end else begin
        cfg_rdata_s = cfg_rdata_s;
      end
    end
    cfg_wen_s = bus.cfg_req_i && bus.cfg_we_i && !cfg_err_s;
  end

  // Priority search: scan from the top so the lowest matching index wins.
  always_comb begin
    lkp_hit_s    = 1'b0;
    lkp_region_s = '0;
    lkp_attr_s   = 3'b000;
    for (int r = int'(NR_REGIONS) - 1; r >= 0; r--) begin
      if (region_match(base_r[r], len_r[r], bus.lkp_addr_i)) begin
        lkp_hit_s    = 1'b1;
        lkp_region_s = IDX_W'(r);
        lkp_attr_s   = attr_r[r][2:0];
      end else begin
        lkp_hit_s    = lkp_hit_s;
      end
    end
  end

  // Region table storage: reset image load and config writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < int'(NR_REGIONS); r++) begin
        base_r[r] <= RST_BASE[r*ADDR_WIDTH +: ADDR_WIDTH];
        len_r[r]  <= RST_LEN[r*ADDR_WIDTH +: ADDR_WIDTH];
        attr_r[r] <= RST_ATTR[r*4 +: 4];
      end
    end else if (cfg_wen_s) begin
      case (cfg_reg_s)
        2'd0:    base_r[cfg_idx_s] <= bus.cfg_wdata_i;
        2'd1:    len_r[cfg_idx_s]  <= bus.cfg_wdata_i;
        2'd2:    attr_r[cfg_idx_s] <= bus.cfg_wdata_i[3:0];
        default: attr_r[cfg_idx_s] <= attr_r[cfg_idx_s];
      endcase
    end
  end

  // Registered config response and lookup result; idle lookups report zeros.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_rvalid_r <= 1'b0;
      cfg_rdata_r  <= '0;
      cfg_err_r    <= 1'b0;
      lkp_valid_r  <= 1'b0;
      lkp_hit_r    <= 1'b0;
      lkp_region_r <= '0;
      lkp_attr_r   <= 3'b000;
    end else begin
      cfg_rvalid_r <= bus.cfg_req_i;
      cfg_rdata_r  <= bus.cfg_req_i ? cfg_rdata_s : '0;
      cfg_err_r    <= bus.cfg_req_i & cfg_err_s;
      lkp_valid_r  <= bus.lkp_valid_i;
      lkp_hit_r    <= bus.lkp_valid_i & lkp_hit_s;
      lkp_region_r <= bus.lkp_valid_i ? lkp_region_s : '0;
      lkp_attr_r   <= bus.lkp_valid_i ? lkp_attr_s : 3'b000;
    end
  end

  assign bus.cfg_rvalid_o  = cfg_rvalid_r;
  assign bus.cfg_rdata_o   = cfg_rdata_r;
  assign bus.cfg_err_o     = cfg_err_r;
  assign bus.lkp_valid_o   = lkp_valid_r;
  assign bus.lkp_hit_o     = lkp_hit_r;
  assign bus.lkp_region_o  = lkp_region_r;
  assign bus.lkp_cached_o  = lkp_attr_r[0];
  assign bus.lkp_exec_o    = lkp_attr_r[1];
  assign bus.lkp_nonidem_o = lkp_attr_r[2];
endmodule

// File: tb/tb_pma_region_table.sv
// tb_pma_region_table
// Directed bench for pma_region_table: reset image, programming, range
// boundaries, priority, lock, overflow edge, write/lookup ordering and reset.
module tb_pma_region_table;
  localparam int unsigned NR = 4;
  localparam int unsigned AW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pma_region_table_if #(.NR_REGIONS(NR), .ADDR_WIDTH(AW)) bus ();

  pma_region_table #(
    .NR_REGIONS (NR),
    .ADDR_WIDTH (AW),
    .RST_BASE   ({64'h0, 64'h0, 64'h0, 64'h0000_0000_8000_0000}),
    .RST_LEN    ({64'h0, 64'h0, 64'h0, 64'h0000_0000_4000_0000}),
    .RST_ATTR   ({4'h0, 4'h0, 4'h0, 4'h3})
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, then sample just after the active edge.
  task automatic step(input logic req, input logic we, input logic [1:0] idx,
                      input logic [1:0] rg, input logic [63:0] wd,
                      input logic lv, input logic [63:0] la);
    bus.cfg_req_i   = req;
    bus.cfg_we_i    = we;
    bus.cfg_addr_i  = {idx, rg};
    bus.cfg_wdata_i = wd;
    bus.lkp_valid_i = lv;
    bus.lkp_addr_i  = la;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input string tag, input logic [1:0] idx, input logic [1:0] rg,
                        input logic [63:0] wd, input logic exp_err);
    step(1'b1, 1'b1, idx, rg, wd, 1'b0, 64'h0);
    check_eq({tag, ".rvalid"}, {63'h0, bus.cfg_rvalid_o}, 64'h1);
    check_eq({tag, ".err"},    {63'h0, bus.cfg_err_o},    {63'h0, exp_err});
    check_eq({tag, ".rdata"},  bus.cfg_rdata_o,           64'h0);
  endtask

  task automatic cfg_rd(input string tag, input logic [1:0] idx, input logic [1:0] rg,
                        input logic [63:0] exp_data, input logic exp_err);
    step(1'b1, 1'b0, idx, rg, 64'h0, 1'b0, 64'h0);
    check_eq({tag, ".rvalid"}, {63'h0, bus.cfg_rvalid_o}, 64'h1);
    check_eq({tag, ".err"},    {63'h0, bus.cfg_err_o},    {63'h0, exp_err});
    check_eq({tag, ".rdata"},  bus.cfg_rdata_o,           exp_data);
  endtask

  // exp_attr is {nonidem, exec, cached}.
  task automatic check_lkp(input string tag, input logic exp_hit,
                           input logic [1:0] exp_region, input logic [2:0] exp_attr);
    check_eq({tag, ".valid"},  {63'h0, bus.lkp_valid_o}, 64'h1);
    check_eq({tag, ".hit"},    {63'h0, bus.lkp_hit_o},   {63'h0, exp_hit});
    check_eq({tag, ".region"}, {62'h0, bus.lkp_region_o}, {62'h0, exp_region});
    check_eq({tag, ".attr"},
             {61'h0, bus.lkp_nonidem_o, bus.lkp_exec_o, bus.lkp_cached_o},
             {61'h0, exp_attr});
  endtask

  task automatic lookup(input string tag, input logic [63:0] addr, input logic exp_hit,
                        input logic [1:0] exp_region, input logic [2:0] exp_attr);
    step(1'b0, 1'b0, 2'd0, 2'd0, 64'h0, 1'b1, addr);
    check_lkp(tag, exp_hit, exp_region, exp_attr);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 2'd0, 2'd0, 64'h0, 1'b0, 64'h0);
    check_eq({tag, ".rvalid"}, {63'h0, bus.cfg_rvalid_o}, 64'h0);
    check_eq({tag, ".lvalid"}, {63'h0, bus.lkp_valid_o},  64'h0);
    check_eq({tag, ".hit"},    {63'h0, bus.lkp_hit_o},    64'h0);
  endtask

  initial begin
    bus.cfg_req_i   = 1'b0;
    bus.cfg_we_i    = 1'b0;
    bus.cfg_addr_i  = 4'h0;
    bus.cfg_wdata_i = 64'h0;
    bus.lkp_valid_i = 1'b0;
    bus.lkp_addr_i  = 64'h0;

    // Reset with a config request and a lookup pending: both dropped.
    rst = 1'b1;
    step(1'b1, 1'b0, 2'd0, 2'd0, 64'h0, 1'b1, 64'h8000_1000);
    check_eq("rst.rvalid", {63'h0, bus.cfg_rvalid_o}, 64'h0);
    check_eq("rst.lvalid", {63'h0, bus.lkp_valid_o},  64'h0);
    check_eq("rst.rdata",  bus.cfg_rdata_o,           64'h0);
    rst = 1'b0;
    idle("post_rst");

    // Reset image of region 0.
    lookup("rst_hit",  64'h8000_1000, 1'b1, 2'd0, 3'b011);
    lookup("rst_miss", 64'h0,         1'b0, 2'd0, 3'b000);
    idle("lkp_idle");

    // Program region 1; ATTR bits above 3 are dropped.
    cfg_wr("wr_r1_base", 2'd1, 2'd0, 64'h1_0000, 1'b0);
    cfg_wr("wr_r1_len",  2'd1, 2'd1, 64'h1_0000, 1'b0);
    cfg_wr("wr_r1_attr", 2'd1, 2'd2, 64'hF6,     1'b0);
    cfg_rd("rd_r1_attr", 2'd1, 2'd2, 64'h6,      1'b0);
    cfg_rd("rd_r1_len",  2'd1, 2'd1, 64'h1_0000, 1'b0);
    idle("cfg_idle");

    lookup("r1_top",   64'h1_FFFF,  1'b1, 2'd1, 3'b110);
    lookup("r1_start", 64'h1_0000,  1'b1, 2'd1, 3'b110);
    lookup("r1_above", 64'h2_0000,  1'b0, 2'd0, 3'b000);
    lookup("r1_below", 64'hFFFF,    1'b0, 2'd0, 3'b000);
    lookup("r0_last",  64'hBFFF_FFFF, 1'b1, 2'd0, 3'b011);
    lookup("r0_end",   64'hC000_0000, 1'b0, 2'd0, 3'b000);

    // Priority: region 2 overlaps region 0 with different attributes.
    cfg_wr("wr_r2_base", 2'd2, 2'd0, 64'h8000_0000, 1'b0);
    cfg_wr("wr_r2_len",  2'd2, 2'd1, 64'h1000,      1'b0);
    cfg_wr("wr_r2_attr", 2'd2, 2'd2, 64'h4,         1'b0);
    lookup("prio", 64'h8000_0000, 1'b1, 2'd0, 3'b011);

    // Write LEN=0 and look up in the same cycle: old table is used.
    step(1'b1, 1'b1, 2'd1, 2'd1, 64'h0, 1'b1, 64'h1_0000);
    check_eq("sim.err", {63'h0, bus.cfg_err_o}, 64'h0);
    check_lkp("sim_same", 1'b1, 2'd1, 3'b110);
    lookup("sim_next", 64'h1_0000, 1'b0, 2'd0, 3'b000);

    // Lock region 1, then every write is refused; reads stay legal.
    cfg_wr("lock_set",   2'd1, 2'd2, 64'h8,   1'b0);
    cfg_wr("lock_base",  2'd1, 2'd0, 64'h5,   1'b1);
    cfg_rd("lock_rd",    2'd1, 2'd0, 64'h1_0000, 1'b0);
    cfg_wr("lock_attr",  2'd1, 2'd2, 64'h0,   1'b1);
    cfg_rd("lock_rd_at", 2'd1, 2'd2, 64'h8,   1'b0);
    cfg_wr("wr_reg3",    2'd0, 2'd3, 64'h123, 1'b1);
    cfg_rd("rd_reg3",    2'd0, 2'd3, 64'h0,   1'b1);

    // Region whose end overflows the address space.
    cfg_wr("wr_r3_base", 2'd3, 2'd0, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
    cfg_wr("wr_r3_len",  2'd3, 2'd1, 64'h20, 1'b0);
    cfg_wr("wr_r3_attr", 2'd3, 2'd2, 64'h1,  1'b0);
    lookup("ovf_top",   64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2'd3, 3'b001);
    lookup("ovf_first", 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 2'd3, 3'b001);
    lookup("ovf_below", 64'hFFFF_FFFF_FFFF_FFEF, 1'b0, 2'd0, 3'b000);
    lookup("ovf_wrap",  64'h8,                   1'b0, 2'd0, 3'b000);

    // Reset mid-stream: the in-flight response is discarded.
    step(1'b1, 1'b0, 2'd0, 2'd0, 64'h0, 1'b1, 64'h8000_0000);
    check_eq("mid.rvalid", {63'h0, bus.cfg_rvalid_o}, 64'h1);
    rst = 1'b1;
    step(1'b1, 1'b0, 2'd0, 2'd0, 64'h0, 1'b1, 64'h8000_0000);
    check_eq("mid_rst.rvalid", {63'h0, bus.cfg_rvalid_o}, 64'h0);
    check_eq("mid_rst.lvalid", {63'h0, bus.lkp_valid_o},  64'h0);
    check_eq("mid_rst.hit",    {63'h0, bus.lkp_hit_o},    64'h0);
    rst = 1'b0;
    idle("mid_post");

    // Lock cleared and table restored to the reset image.
    cfg_rd("rst_r1_attr", 2'd1, 2'd2, 64'h0, 1'b0);
    cfg_rd("rst_r1_base", 2'd1, 2'd0, 64'h0, 1'b0);
    cfg_rd("rst_r0_base", 2'd0, 2'd0, 64'h8000_0000, 1'b0);
    cfg_wr("unlock_wr",   2'd1, 2'd0, 64'h5, 1'b0);
    cfg_rd("unlock_rd",   2'd1, 2'd0, 64'h5, 1'b0);
    lookup("rst_ovf_gone", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'd0, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
